// File: rtl/adder_sched_pkg.sv
// rtl/adder_sched_pkg.sv - shared types, defaults and round-robin pick helper for adder_rr_sched
package adder_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEFAULT_NUM_REQ = 4;
  localparam int DEFAULT_DATA_W  = 4;

  // Returns {found, index[2:0]}: first set bit of req scanning upward from last+1, wrapping at n.
  function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] last,
                                         input logic [3:0] n);
    logic [3:0] res;
    logic [3:0] idx;
    res = '0;
    for (int k = 1; k <= 8; k++) begin
      idx = {1'b0, last} + 4'(k);
      if (idx >= n) idx = idx - n;
      if (k <= int'(n) && !res[3] && req[idx[2:0]]) res = {1'b1, idx[2:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/adder_rr_sched_rr_arbiter.sv
// rtl/adder_rr_sched_rr_arbiter.sv - combinational round-robin pick from a request vector
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic               o_found,
  output logic [IDX_W-1:0]   o_idx
);

  logic [3:0] w_pick;

  assign w_pick  = rr_pick(8'(i_req), 3'(i_last), 4'(NUM_REQ));
  assign o_found = w_pick[3];
  assign o_idx   = IDX_W'(w_pick[2:0]);

endmodule

// File: rtl/adder_rr_sched.sv
// rtl/adder_rr_sched.sv - round-robin scheduler sharing one external adder among NUM_REQ requesters
module adder_rr_sched
  import adder_sched_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int DATA_W  = DEFAULT_DATA_W,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W:0]           rsp_sum,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         add_a,
  output logic [DATA_W-1:0]         add_b,
  input  logic [DATA_W:0]           add_s,
  output logic                      busy,
  output logic [IDX_W-1:0]          grant_id
);

  state_e             r_state;
  state_e             w_next;
  logic [IDX_W-1:0]   r_last_grant;
  logic [IDX_W-1:0]   r_grant_id;
  logic [DATA_W-1:0]  r_op_a;
  logic [DATA_W-1:0]  r_op_b;
  logic [DATA_W:0]    r_rsp_sum;
  logic               w_found;
  logic [IDX_W-1:0]   w_pick;
  logic               w_accept;
  logic               w_release;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req   (req_valid),
    .i_last  (r_last_grant),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Handshake outputs are masked during reset so an aborted transaction never shows valid/ready.
  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    rsp_valid = '0;
    w_accept  = 1'b0;
    w_release = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found && !rst) begin
          req_ready = NUM_REQ'(1) << w_pick;
          w_accept  = 1'b1;
          w_next    = CALC;
        end
      end
      CALC: w_next = RESP;
      RESP: begin
        if (!rst) rsp_valid = NUM_REQ'(1) << r_grant_id;
        if (rsp_ready) begin
          w_release = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_rsp_sum    <= '0;
      r_grant_id   <= '0;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
    end else begin
      if (w_accept) begin
        r_op_a     <= req_a[w_pick*DATA_W +: DATA_W];
        r_op_b     <= req_b[w_pick*DATA_W +: DATA_W];
        r_grant_id <= w_pick;
      end
      if (r_state == CALC) r_rsp_sum <= add_s;
      if (w_release) r_last_grant <= r_grant_id;
    end
  end

  assign add_a    = r_op_a;
  assign add_b    = r_op_b;
  assign rsp_sum  = r_rsp_sum;
  assign grant_id = r_grant_id;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_adder_rr_sched.sv
// tb/tb_adder_rr_sched.sv - directed table-driven bench for adder_rr_sched with a behavioural adder
module tb_adder_rr_sched;

  localparam int NR = 4;
  localparam int DW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*DW-1:0] req_a;
  logic [NR*DW-1:0] req_b;
  logic [NR-1:0]   rsp_valid;
  logic [DW:0]     rsp_sum;
  logic            rsp_ready;
  logic [DW-1:0]   add_a;
  logic [DW-1:0]   add_b;
  logic [DW:0]     add_s;
  logic            busy;
  logic [1:0]      grant_id;

  adder_rr_sched #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_sum   (rsp_sum),
    .rsp_ready (rsp_ready),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_s     (add_s),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  // The shared adder instance the scheduler drives.
  assign add_s = {1'b0, add_a} + {1'b0, add_b};

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    int         idx;
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] sum;
  } vec_t;

  vec_t tab[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_ops(input int idx, input logic [3:0] a, input logic [3:0] b);
    req_a[idx*DW +: DW] = a;
    req_b[idx*DW +: DW] = b;
  endtask

  // Full single-requester transaction with rsp_ready held high; starts and ends in IDLE.
  task automatic do_txn(input int idx, input logic [3:0] a, input logic [3:0] b,
                        input logic [4:0] sum);
    logic [NR-1:0] oh;
    oh = NR'(1) << idx;
    set_ops(idx, a, b);
    req_valid = oh;
    #1;
    chk("accept_ready", req_ready, oh);
    chk("accept_busy", busy, 0);
    tick();
    req_valid = '0;
    #1;
    chk("calc_add_a", add_a, a);
    chk("calc_add_b", add_b, b);
    chk("calc_ready", req_ready, 0);
    chk("calc_busy", busy, 1);
    chk("calc_rsp_valid", rsp_valid, 0);
    tick();
    chk("resp_valid", rsp_valid, oh);
    chk("resp_sum", rsp_sum, sum);
    chk("resp_grant", grant_id, idx);
    tick();
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_grant_hold", grant_id, idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0] = '{1, 4'h9, 4'h8, 5'h11};
    tab[1] = '{0, 4'hF, 4'hF, 5'h1E};
    tab[2] = '{3, 4'h0, 4'h0, 5'h00};
    tab[3] = '{2, 4'hA, 4'h6, 5'h10};
    tab[4] = '{1, 4'h7, 4'h8, 5'h0F};

    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    do_reset();

    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);

    for (int i = 0; i < 5; i++) do_txn(tab[i].idx, tab[i].a, tab[i].b, tab[i].sum);

    // Reset while a result is waiting in RESP.
    set_ops(1, 4'h3, 4'h4);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    chk("pre_rst_rsp_valid", rsp_valid, 4'b0010);
    rst = 1'b1;
    tick();
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_rsp_sum", rsp_sum, 0);
    chk("mid_rst_add_a", add_a, 0);
    chk("mid_rst_add_b", add_b, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_grant", grant_id, 0);
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk("post_rst_busy", busy, 0);
    do_txn(3, 4'h5, 4'h6, 5'h0B);

    // Fairness: all four requesting continuously.
    do_reset();
    for (int i = 0; i < NR; i++) set_ops(i, 4'(i + 5), 4'(2 * i + 7));
    req_valid = 4'b1111;
    begin
      logic [4:0] rr_sum[4];
      rr_sum[0] = 5'h0C;
      rr_sum[1] = 5'h0F;
      rr_sum[2] = 5'h12;
      rr_sum[3] = 5'h15;
      for (int g = 0; g < 5; g++) begin
        #1;
        chk("rr_ready", req_ready, NR'(1) << (g % NR));
        tick();
        tick();
        chk("rr_rsp_valid", rsp_valid, NR'(1) << (g % NR));
        chk("rr_rsp_sum", rsp_sum, rr_sum[g % NR]);
        tick();
      end
    end

    // Backpressure: hold RESP for 5 cycles with others still requesting.
    do_reset();
    req_valid = 4'b1111;
    #1;
    chk("bp_accept", req_ready, 4'b0001);
    tick();
    rsp_ready = 1'b0;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_rsp_valid", rsp_valid, 4'b0001);
      chk("bp_rsp_sum", rsp_sum, 5'h0C);
      chk("bp_req_ready", req_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_valid", rsp_valid, 4'b0001);
    tick();
    chk("bp_next_ready", req_ready, 4'b0010);
    chk("bp_idle_rsp_valid", rsp_valid, 0);

    // Wrap/skip: last_grant=2, requesters 0 and 2 pending.
    req_valid = '0;
    do_reset();
    do_txn(2, 4'h1, 4'h2, 5'h03);
    set_ops(0, 4'h4, 4'h4);
    set_ops(2, 4'hC, 4'h5);
    req_valid = 4'b0101;
    #1;
    chk("wrap_ready0", req_ready, 4'b0001);
    tick();
    tick();
    chk("wrap_rsp0_valid", rsp_valid, 4'b0001);
    chk("wrap_rsp0_sum", rsp_sum, 5'h08);
    tick();
    chk("wrap_ready2", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    tick();
    chk("wrap_rsp2_valid", rsp_valid, 4'b0100);
    chk("wrap_rsp2_sum", rsp_sum, 5'h11);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
